// File: rtl/ifetch_bus_ctrl.sv
// rtl/ifetch_bus_ctrl.sv - instruction-side bus controller with fetch/debug arbitration
module ifetch_bus_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rstn,
    input  logic [ADDR_WIDTH-1:0]  next_pc,
    output logic                   instr_read_data_valid,
    output logic [INSTR_WIDTH-1:0] instr_read_data,
    input  logic                   dbg_req,
    input  logic                   dbg_we,
    input  logic [ADDR_WIDTH-1:0]  dbg_addr,
    input  logic [INSTR_WIDTH-1:0] dbg_wdata,
    output logic                   dbg_gnt,
    output logic                   dbg_rvalid,
    output logic [INSTR_WIDTH-1:0] dbg_rdata,
    output logic                   bus_req,
    output logic                   bus_we,
    output logic [ADDR_WIDTH-1:0]  bus_addr,
    output logic [INSTR_WIDTH-1:0] bus_wdata,
    input  logic                   bus_gnt,
    input  logic                   bus_rvalid,
    input  logic [INSTR_WIDTH-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } state_t;

    typedef enum logic {
        OWN_FETCH,
        OWN_DBG
    } owner_t;

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    state_t                 state, state_nxt;
    owner_t                 owner, owner_nxt;
    logic                   dbg_prio, dbg_prio_nxt;
    logic                   stale, stale_nxt;
    logic [ADDR_WIDTH-1:0]  req_addr, req_addr_nxt;
    logic                   req_we, req_we_nxt;
    logic [INSTR_WIDTH-1:0] req_wdata, req_wdata_nxt;

    logic                   pc_match;
    logic                   resp_fire;
    logic                   issue;

    assign pc_match  = (next_pc == req_addr);
    assign resp_fire = (state == ST_RESP) && bus_rvalid;

    // Request attributes are registered at REQ entry so the bus sees a stable request.
    assign bus_req   = (state == ST_REQ);
    assign bus_we    = req_we;
    assign bus_addr  = req_addr;
    assign bus_wdata = req_wdata;
    assign dbg_gnt   = bus_req && bus_gnt && (owner == OWN_DBG);

    // Responses pass straight through; fetch data is qualified by the live next_pc.
    assign instr_read_data_valid = resp_fire && (owner == OWN_FETCH) && !stale && pc_match;
    assign instr_read_data       = instr_read_data_valid ? bus_rdata : '0;
    assign dbg_rvalid            = resp_fire && (owner == OWN_DBG);
    assign dbg_rdata             = dbg_rvalid ? bus_rdata : '0;

    // Next-state, arbitration and stale tracking.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        dbg_prio_nxt  = dbg_prio;
        stale_nxt     = stale;
        req_addr_nxt  = req_addr;
        req_we_nxt    = req_we;
        req_wdata_nxt = req_wdata;
        issue         = 1'b0;

        if ((owner == OWN_FETCH) && (state != ST_IDLE) && !pc_match) begin
            stale_nxt = 1'b1;
        end

        case (state)
            ST_IDLE: begin
                issue = 1'b1;
            end
            ST_REQ: begin
                if (bus_gnt) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus_rvalid) begin
                    // Finishing a fetch hands priority to debug, finishing debug takes it back.
                    dbg_prio_nxt = (owner == OWN_FETCH);
                    issue        = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (issue) begin
            state_nxt = ST_REQ;
            stale_nxt = 1'b0;
            if (dbg_req && dbg_prio_nxt) begin
                owner_nxt     = OWN_DBG;
                req_addr_nxt  = dbg_addr & WORD_MASK;
                req_we_nxt    = dbg_we;
                req_wdata_nxt = dbg_wdata;
            end else begin
                owner_nxt     = OWN_FETCH;
                req_addr_nxt  = next_pc & WORD_MASK;
                req_we_nxt    = 1'b0;
                req_wdata_nxt = '0;
            end
        end
    end

    // State register; reset drops any transaction in flight.
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state     <= ST_IDLE;
            owner     <= OWN_FETCH;
            dbg_prio  <= 1'b1;
            stale     <= 1'b0;
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            dbg_prio  <= dbg_prio_nxt;
            stale     <= stale_nxt;
            req_addr  <= req_addr_nxt;
            req_we    <= req_we_nxt;
            req_wdata <= req_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_ifetch_bus_ctrl.sv
// tb/tb_ifetch_bus_ctrl.sv - directed self-checking bench for ifetch_bus_ctrl
module tb_ifetch_bus_ctrl;

    logic        cpu_clk;
    logic        cpu_rstn;
    logic        bus_rstn;
    logic [31:0] next_pc;
    logic        instr_read_data_valid;
    logic [31:0] instr_read_data;
    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    logic        gnt_en;
    int          resp_delay;
    logic        advance;
    int          total;
    int          bad;
    int          cyc;

    logic [31:0] mem [0:1023];
    logic        pend;
    int          pcnt;
    logic [31:0] paddr;

    logic [31:0] g_addr [$];
    logic        g_dbg  [$];
    logic [31:0] v_data [$];
    int          v_cyc  [$];
    logic [31:0] d_data [$];

    ifetch_bus_ctrl #(
        .ADDR_WIDTH (32),
        .INSTR_WIDTH(32)
    ) dut (
        .cpu_clk              (cpu_clk),
        .cpu_rstn             (cpu_rstn),
        .next_pc              (next_pc),
        .instr_read_data_valid(instr_read_data_valid),
        .instr_read_data      (instr_read_data),
        .dbg_req              (dbg_req),
        .dbg_we               (dbg_we),
        .dbg_addr             (dbg_addr),
        .dbg_wdata            (dbg_wdata),
        .dbg_gnt              (dbg_gnt),
        .dbg_rvalid           (dbg_rvalid),
        .dbg_rdata            (dbg_rdata),
        .bus_req              (bus_req),
        .bus_we               (bus_we),
        .bus_addr             (bus_addr),
        .bus_wdata            (bus_wdata),
        .bus_gnt              (bus_gnt),
        .bus_rvalid           (bus_rvalid),
        .bus_rdata            (bus_rdata)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    assign bus_gnt = bus_req & gnt_en;

    function automatic logic [9:0] mem_idx(input logic [31:0] a);
        return {a[29], a[10:2]};
    endfunction

    function automatic logic [31:0] init_word(input logic [9:0] i);
        case (i)
            10'd0:   return 32'h0000_0013;
            10'd1:   return 32'h0010_0093;
            10'd4:   return 32'h1234_5678;
            10'd512: return 32'hCAFE_F00D;
            10'd513: return 32'h0BAD_C0DE;
            default: return 32'hC0DE_0000 | {22'd0, i};
        endcase
    endfunction

    // Memory model: grant accepted with req, response after resp_delay extra cycles.
    always @(posedge cpu_clk or negedge bus_rstn) begin
        if (!bus_rstn) begin
            bus_rvalid <= 1'b0;
            bus_rdata  <= 32'h0;
            pend       <= 1'b0;
            pcnt       <= 0;
            paddr      <= 32'h0;
            for (int i = 0; i < 1024; i++) begin
                mem[i] <= init_word(10'(i));
            end
        end else begin
            bus_rvalid <= 1'b0;
            if (bus_req && bus_gnt) begin
                if (bus_we) begin
                    mem[mem_idx(bus_addr)] <= bus_wdata;
                end
                if (resp_delay == 0) begin
                    bus_rvalid <= 1'b1;
                    bus_rdata  <= mem[mem_idx(bus_addr)];
                end else begin
                    pend  <= 1'b1;
                    pcnt  <= resp_delay - 1;
                    paddr <= bus_addr;
                end
            end else if (pend) begin
                if (pcnt == 0) begin
                    bus_rvalid <= 1'b1;
                    bus_rdata  <= mem[mem_idx(paddr)];
                    pend       <= 1'b0;
                end else begin
                    pcnt <= pcnt - 1;
                end
            end
        end
    end

    task automatic sample_cycle();
        @(negedge cpu_clk);
        cyc++;
        if (bus_req && bus_gnt) begin
            g_addr.push_back(bus_addr);
            g_dbg.push_back(dbg_gnt);
        end
        if (instr_read_data_valid) begin
            v_data.push_back(instr_read_data);
            v_cyc.push_back(cyc);
            if (advance) next_pc = next_pc + 32'd4;
        end
        if (dbg_rvalid) d_data.push_back(dbg_rdata);
    endtask

    task automatic do_reset(input logic [31:0] pc, input logic with_bus);
        cpu_rstn = 1'b0;
        if (with_bus) bus_rstn = 1'b0;
        next_pc = pc;
        dbg_req = 1'b0;
        dbg_we  = 1'b0;
        g_addr.delete();
        g_dbg.delete();
        v_data.delete();
        v_cyc.delete();
        d_data.delete();
        repeat (2) @(negedge cpu_clk);
        cpu_rstn = 1'b1;
        bus_rstn = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        cpu_rstn = 1'b0;
        next_pc  = 32'h1234;
        dbg_req  = 1'b1;
        repeat (3) @(negedge cpu_clk);
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL reset_bus_req got %b want 0", bus_req); end
        total++; if (bus_addr !== 32'h0) begin bad++; $display("FAIL reset_bus_addr got %h want 0", bus_addr); end
        total++; if (bus_we !== 1'b0) begin bad++; $display("FAIL reset_bus_we got %b want 0", bus_we); end
        total++; if (bus_wdata !== 32'h0) begin bad++; $display("FAIL reset_bus_wdata got %h want 0", bus_wdata); end
        total++; if (instr_read_data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", instr_read_data_valid); end
        total++; if (instr_read_data !== 32'h0) begin bad++; $display("FAIL reset_idata got %h want 0", instr_read_data); end
        total++; if (dbg_gnt !== 1'b0) begin bad++; $display("FAIL reset_dbg_gnt got %b want 0", dbg_gnt); end
        total++; if (dbg_rvalid !== 1'b0) begin bad++; $display("FAIL reset_dbg_rvalid got %b want 0", dbg_rvalid); end
        total++; if (dbg_rdata !== 32'h0) begin bad++; $display("FAIL reset_dbg_rdata got %h want 0", dbg_rdata); end
        dbg_req = 1'b0;
    endtask

    task automatic test_sequential();
        resp_delay = 0;
        gnt_en     = 1'b1;
        advance    = 1'b1;
        do_reset(32'h0, 1'b1);
        repeat (4) sample_cycle();
        total++; if (v_data.size() != 2) begin bad++; $display("FAIL seq_count got %0d want 2", v_data.size()); end
        total++; if (v_data.size() < 1 || v_data[0] !== 32'h0000_0013) begin bad++; $display("FAIL seq_data0 got %h want 00000013", v_data.size() < 1 ? 32'hx : v_data[0]); end
        total++; if (v_data.size() < 2 || v_data[1] !== 32'h0010_0093) begin bad++; $display("FAIL seq_data1 got %h want 00100093", v_data.size() < 2 ? 32'hx : v_data[1]); end
        total++; if (g_addr.size() < 2 || g_addr[0] !== 32'h0 || g_addr[1] !== 32'h4) begin bad++; $display("FAIL seq_addrs got %0d grants want 0x0,0x4", g_addr.size()); end
        total++; if (v_cyc.size() < 2 || v_cyc[0] != 2 || v_cyc[1] != 4) begin bad++; $display("FAIL seq_timing got first=%0d want cycles 2,4", v_cyc.size() < 1 ? -1 : v_cyc[0]); end
    endtask

    task automatic test_redirect();
        resp_delay = 2;
        gnt_en     = 1'b1;
        advance    = 1'b1;
        do_reset(32'h100, 1'b1);
        repeat (2) sample_cycle();
        next_pc = 32'h200;
        repeat (7) sample_cycle();
        total++; if (g_addr.size() < 2 || g_addr[0] !== 32'h100 || g_addr[1] !== 32'h200) begin bad++; $display("FAIL redir_addrs got %h want 100 then 200", g_addr.size() < 2 ? 32'hx : g_addr[1]); end
        total++; if (v_data.size() != 1) begin bad++; $display("FAIL redir_count got %0d want 1", v_data.size()); end
        total++; if (v_data.size() < 1 || v_data[0] !== 32'hC0DE_0080) begin bad++; $display("FAIL redir_data got %h want c0de0080", v_data.size() < 1 ? 32'hx : v_data[0]); end
    endtask

    task automatic test_wait_states();
        resp_delay = 0;
        gnt_en     = 1'b0;
        advance    = 1'b1;
        do_reset(32'h40, 1'b1);
        sample_cycle();
        total++; if (bus_req !== 1'b1 || bus_addr !== 32'h40) begin bad++; $display("FAIL wait_c1 got req=%b addr=%h want 1 40", bus_req, bus_addr); end
        next_pc = 32'h80;
        for (int i = 2; i <= 3; i++) begin
            sample_cycle();
            total++; if (bus_req !== 1'b1 || bus_addr !== 32'h40) begin bad++; $display("FAIL wait_c%0d got req=%b addr=%h want 1 40", i, bus_req, bus_addr); end
        end
        gnt_en = 1'b1;
        sample_cycle();
        total++; if (bus_req !== 1'b0 || bus_addr !== 32'h40 || instr_read_data_valid !== 1'b0) begin bad++; $display("FAIL wait_drop got req=%b addr=%h valid=%b want 0 40 0", bus_req, bus_addr, instr_read_data_valid); end
        repeat (4) sample_cycle();
        total++; if (g_addr.size() < 1 || g_addr[0] !== 32'h80) begin bad++; $display("FAIL wait_next_addr got %h want 80", g_addr.size() < 1 ? 32'hx : g_addr[0]); end
        total++; if (v_data.size() < 1 || v_data[0] !== 32'hC0DE_0020) begin bad++; $display("FAIL wait_data got %h want c0de0020", v_data.size() < 1 ? 32'hx : v_data[0]); end
    endtask

    task automatic test_contention();
        int ngnt;
        ngnt       = 0;
        resp_delay = 0;
        gnt_en     = 1'b1;
        advance    = 1'b1;
        do_reset(32'h0, 1'b1);
        dbg_req  = 1'b1;
        dbg_we   = 1'b0;
        dbg_addr = 32'h2000_0000;
        for (int i = 0; i < 8; i++) begin
            sample_cycle();
            if (dbg_gnt) begin
                ngnt++;
                if (ngnt == 1) dbg_addr = 32'h2000_0004;
                else dbg_req = 1'b0;
            end
        end
        total++; if (g_addr.size() < 4 || g_addr[0] !== 32'h2000_0000 || g_addr[1] !== 32'h0 || g_addr[2] !== 32'h2000_0004 || g_addr[3] !== 32'h4) begin bad++; $display("FAIL cont_order got %0d grants want dbg0,f0,dbg4,f4", g_addr.size()); end
        total++; if (g_dbg.size() < 4 || g_dbg[0] !== 1'b1 || g_dbg[1] !== 1'b0 || g_dbg[2] !== 1'b1 || g_dbg[3] !== 1'b0) begin bad++; $display("FAIL cont_owner got size %0d want 1,0,1,0", g_dbg.size()); end
        total++; if (d_data.size() != 2 || d_data[0] !== 32'hCAFE_F00D || d_data[1] !== 32'h0BAD_C0DE) begin bad++; $display("FAIL cont_dbg_data got %0d responses want cafef00d,0badc0de", d_data.size()); end
        total++; if (v_data.size() < 1 || v_data[0] !== 32'h0000_0013) begin bad++; $display("FAIL cont_fetch_data got %h want 00000013", v_data.size() < 1 ? 32'hx : v_data[0]); end
    endtask

    task automatic test_dbg_write();
        resp_delay = 0;
        gnt_en     = 1'b1;
        advance    = 1'b1;
        do_reset(32'h10, 1'b1);
        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 32'h10;
        dbg_wdata = 32'hDEAD_BEEF;
        sample_cycle();
        total++; if (bus_we !== 1'b1 || bus_wdata !== 32'hDEAD_BEEF || bus_addr !== 32'h10 || dbg_gnt !== 1'b1) begin bad++; $display("FAIL dw_req got we=%b wdata=%h addr=%h gnt=%b want 1 deadbeef 10 1", bus_we, bus_wdata, bus_addr, dbg_gnt); end
        dbg_req = 1'b0;
        dbg_we  = 1'b0;
        sample_cycle();
        total++; if (dbg_rvalid !== 1'b1 || instr_read_data_valid !== 1'b0) begin bad++; $display("FAIL dw_resp got rvalid=%b ivalid=%b want 1 0", dbg_rvalid, instr_read_data_valid); end
        sample_cycle();
        total++; if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 32'h10) begin bad++; $display("FAIL dw_fetch_req got req=%b we=%b addr=%h want 1 0 10", bus_req, bus_we, bus_addr); end
        sample_cycle();
        total++; if (v_data.size() != 1 || v_data[0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL dw_readback got %h want deadbeef", v_data.size() < 1 ? 32'hx : v_data[0]); end
    endtask

    task automatic test_reset_mid();
        resp_delay = 3;
        gnt_en     = 1'b1;
        advance    = 1'b1;
        do_reset(32'h300, 1'b1);
        repeat (2) sample_cycle();
        cpu_rstn = 1'b0;
        #1;
        total++; if (bus_req !== 1'b0 || bus_addr !== 32'h0 || instr_read_data_valid !== 1'b0) begin bad++; $display("FAIL rmid_async got req=%b addr=%h valid=%b want 0 0 0", bus_req, bus_addr, instr_read_data_valid); end
        next_pc = 32'h400;
        gnt_en  = 1'b0;
        sample_cycle();
        cpu_rstn = 1'b1;
        sample_cycle();
        total++; if (bus_req !== 1'b1 || bus_addr !== 32'h400) begin bad++; $display("FAIL rmid_restart got req=%b addr=%h want 1 400", bus_req, bus_addr); end
        sample_cycle();
        total++; if (bus_rvalid !== 1'b1 || instr_read_data_valid !== 1'b0 || bus_req !== 1'b1) begin bad++; $display("FAIL rmid_unsolicited got rvalid=%b valid=%b req=%b want 1 0 1", bus_rvalid, instr_read_data_valid, bus_req); end
        resp_delay = 0;
        gnt_en     = 1'b1;
        sample_cycle();
        total++; if (v_data.size() != 1 || v_data[0] !== 32'hC0DE_0100) begin bad++; $display("FAIL rmid_data got %0d pulses want 1 with c0de0100", v_data.size()); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        cyc        = 0;
        cpu_rstn   = 1'b0;
        bus_rstn   = 1'b0;
        next_pc    = 32'h0;
        dbg_req    = 1'b0;
        dbg_we     = 1'b0;
        dbg_addr   = 32'h0;
        dbg_wdata  = 32'h0;
        gnt_en     = 1'b1;
        resp_delay = 0;
        advance    = 1'b1;
        test_reset();
        test_sequential();
        test_redirect();
        test_wait_states();
        test_contention();
        test_dbg_write();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
